// File: rtl/fft_magni_peak_if.sv
// Streaming bin bus: one bin per valid cycle, carrying its address and frame-last flag.
interface fft_magni_peak_if #(
  parameter int DATA_W = 80,
  parameter int ADDR_W = 16
);
  logic              valid;
  logic [DATA_W-1:0] data;
  logic [ADDR_W-1:0] addr;
  logic              last;

  modport master (output valid, data, addr, last);
  modport slave  (input  valid, data, addr, last);
endinterface

// File: rtl/fft_magni_peak.sv
// FFT bin magnitude (alpha-max-plus-beta-min, 3-stage pipeline) with per-frame
// windowed peak search and framing-error detection on the output side.
module fft_magni_peak #(
  parameter int IN_W      = 40,
  parameter int ADDR_W    = 16,
  parameter int MAG_W     = 16,
  parameter int MAG_SHIFT = 24,
  parameter int FRAME_LEN = 16384,
  parameter int FCNT_W    = 8
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  fft_magni_peak_if.slave   s_axis_fft,
  fft_magni_peak_if.master  m_axis_fftmagni,
  input  logic [ADDR_W-1:0] cfg_pk_lo,
  input  logic [ADDR_W-1:0] cfg_pk_hi,
  output logic              peak_valid,
  output logic [MAG_W-1:0]  peak_mag,
  output logic [ADDR_W-1:0] peak_addr,
  output logic              peak_none,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic              event_tlast_missing,
  output logic              event_tlast_unexpected
);
  localparam int RAW_W = IN_W + 1;
  localparam int CMP_W = (RAW_W > MAG_W) ? RAW_W : MAG_W;
  localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [IDX_W-1:0] IDX_END = IDX_W'(FRAME_LEN - 1);
  localparam logic [CMP_W-1:0] SAT = CMP_W'({MAG_W{1'b1}});
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [IN_W-1:0]   re, im;
  logic [IN_W-1:0]   absRe_d, absIm_d, absRe_q, absIm_q;
  logic [IN_W-1:0]   max_d, min_d, max_q, min_q;
  logic [RAW_W-1:0]  raw, shifted;
  logic [CMP_W-1:0]  wide;
  logic [MAG_W-1:0]  mag3_d, mag3_q;
  logic              v1_q, v2_q, v3_q, last1_q, last2_q, last3_q;
  logic [ADDR_W-1:0] addr1_q, addr2_q, addr3_q;

  logic [IDX_W-1:0]  idx_d, idx_q;
  logic [0:0]        state_d, state_q;
  logic [ADDR_W-1:0] lo_d, lo_q, hi_d, hi_q, loEff, hiEff;
  logic [MAG_W-1:0]  best_d, best_q, trkMag;
  logic [ADDR_W-1:0] bestAddr_d, bestAddr_q, trkAddr;
  logic              found_d, found_q, trkFound;
  logic              atEnd, close, first, inWin, take;
  logic              peakValid_d, peakValid_q, peakNone_d, peakNone_q;
  logic [MAG_W-1:0]  peakMag_d, peakMag_q;
  logic [ADDR_W-1:0] peakAddr_d, peakAddr_q;
  logic [FCNT_W-1:0] frameCnt_d, frameCnt_q;

  assign re = s_axis_fft.data[IN_W-1:0];
  assign im = s_axis_fft.data[2*IN_W-1:IN_W];

  // Unsigned magnitudes stay IN_W wide so the most negative input maps exactly.
  always_comb begin
    absRe_d = re[IN_W-1] ? (~re + IN_W'(1)) : re;
    absIm_d = im[IN_W-1] ? (~im + IN_W'(1)) : im;
    max_d   = (absRe_q >= absIm_q) ? absRe_q : absIm_q;
    min_d   = (absRe_q >= absIm_q) ? absIm_q : absRe_q;
    raw     = {1'b0, max_q} + {1'b0, min_q >> 2} + {1'b0, min_q >> 3};
    shifted = raw >> MAG_SHIFT;
    wide    = CMP_W'(shifted);
    mag3_d  = (wide > SAT) ? {MAG_W{1'b1}} : wide[MAG_W-1:0];
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      v1_q <= 1'b0; v2_q <= 1'b0; v3_q <= 1'b0;
      last1_q <= 1'b0; last2_q <= 1'b0; last3_q <= 1'b0;
      addr1_q <= '0; addr2_q <= '0; addr3_q <= '0;
      absRe_q <= '0; absIm_q <= '0; max_q <= '0; min_q <= '0; mag3_q <= '0;
    end else begin
      v1_q <= s_axis_fft.valid; last1_q <= s_axis_fft.last; addr1_q <= s_axis_fft.addr;
      absRe_q <= absRe_d; absIm_q <= absIm_d;
      v2_q <= v1_q; last2_q <= last1_q; addr2_q <= addr1_q;
      max_q <= max_d; min_q <= min_d;
      v3_q <= v2_q; last3_q <= last2_q; addr3_q <= addr2_q;
      mag3_q <= mag3_d;
    end
  end

  // The first bin of a frame is judged against the live bounds, which are latched for the rest.
  always_comb begin
    atEnd    = (idx_q == IDX_END);
    close    = v3_q & (last3_q | atEnd);
    first    = (state_q == ST_IDLE);
    loEff    = first ? cfg_pk_lo : lo_q;
    hiEff    = first ? cfg_pk_hi : hi_q;
    inWin    = (addr3_q >= loEff) && (addr3_q <= hiEff);
    take     = v3_q && inWin && (first || !found_q || (mag3_q > best_q));
    trkFound = take || (!first && found_q);
    trkMag   = take ? mag3_q : best_q;
    trkAddr  = take ? addr3_q : bestAddr_q;

    idx_d       = idx_q;
    state_d     = state_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    found_d     = found_q;
    best_d      = best_q;
    bestAddr_d  = bestAddr_q;
    peakValid_d = 1'b0;
    peakNone_d  = peakNone_q;
    peakMag_d   = peakMag_q;
    peakAddr_d  = peakAddr_q;
    frameCnt_d  = frameCnt_q;

    if (v3_q) begin
      idx_d      = idx_q + IDX_W'(1);
      found_d    = trkFound;
      best_d     = trkMag;
      bestAddr_d = trkAddr;
      if (first) begin
        lo_d    = cfg_pk_lo;
        hi_d    = cfg_pk_hi;
        state_d = ST_RUN;
      end
    end
    if (close) begin
      idx_d       = '0;
      state_d     = ST_IDLE;
      found_d     = 1'b0;
      peakValid_d = 1'b1;
      peakNone_d  = !trkFound;
      peakMag_d   = trkFound ? trkMag : '0;
      peakAddr_d  = trkFound ? trkAddr : loEff;
      frameCnt_d  = frameCnt_q + FCNT_W'(1);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      idx_q <= '0; state_q <= ST_IDLE; lo_q <= '0; hi_q <= '0;
      found_q <= 1'b0; best_q <= '0; bestAddr_q <= '0;
      peakValid_q <= 1'b0; peakNone_q <= 1'b0; peakMag_q <= '0; peakAddr_q <= '0;
      frameCnt_q <= '0;
    end else begin
      idx_q <= idx_d; state_q <= state_d; lo_q <= lo_d; hi_q <= hi_d;
      found_q <= found_d; best_q <= best_d; bestAddr_q <= bestAddr_d;
      peakValid_q <= peakValid_d; peakNone_q <= peakNone_d;
      peakMag_q <= peakMag_d; peakAddr_q <= peakAddr_d;
      frameCnt_q <= frameCnt_d;
    end
  end

  assign m_axis_fftmagni.valid  = v3_q;
  assign m_axis_fftmagni.data   = mag3_q;
  assign m_axis_fftmagni.addr   = addr3_q;
  assign m_axis_fftmagni.last   = last3_q | (v3_q & atEnd);
  assign event_tlast_unexpected = v3_q & last3_q & !atEnd;
  assign event_tlast_missing    = v3_q & atEnd & !last3_q;
  assign peak_valid             = peakValid_q;
  assign peak_mag               = peakMag_q;
  assign peak_addr              = peakAddr_q;
  assign peak_none              = peakNone_q;
  assign frame_cnt              = frameCnt_q;
endmodule

// File: tb/tb_fft_magni_peak.sv
// Bench for fft_magni_peak: directed and random frames checked against a
// frame-level reference model (magnitude formula, window scan, framing rules).
module tb_fft_magni_peak;
  localparam int IN_W   = 16;
  localparam int ADDR_W = 16;
  localparam int MAG_W  = 16;
  localparam int FLEN   = 8;
  localparam int FCNT_W = 8;

  typedef struct {
    bit vld;
    int mag;
    int mag12;
    int addr;
    bit last;
    bit evU;
    bit evM;
    bit close;
    int pkMag;
    int pkAddr;
    int pkMag12;
    int pkAddr12;
    bit pkNone;
    int fcnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic [ADDR_W-1:0] cfgLo, cfgHi;
  logic peakValid, peakNone, evMissing, evUnexp;
  logic [MAG_W-1:0] peakMag;
  logic [ADDR_W-1:0] peakAddr;
  logic [FCNT_W-1:0] frameCnt;
  logic p12Valid, p12None, ev12Missing, ev12Unexp;
  logic [11:0] p12Mag;
  logic [ADDR_W-1:0] p12Addr;
  logic [FCNT_W-1:0] f12Cnt;

  int checkCount = 0;
  int passCount = 0;
  exp_t expQ[$];
  exp_t pendPeak;
  bit pend = 1'b0;
  int idx = 0;
  int frameCount = 0;
  int latLo, latHi;
  int fMag[$], fMag12[$], fAddr[$];
  int pkMags[8] = '{900, 10, 40, 70, 70, 20, 10, 999};

  always #5 clk = ~clk;

  fft_magni_peak_if #(.DATA_W(2*IN_W), .ADDR_W(ADDR_W)) sIf ();
  fft_magni_peak_if #(.DATA_W(MAG_W), .ADDR_W(ADDR_W)) mIf ();
  fft_magni_peak_if #(.DATA_W(12), .ADDR_W(ADDR_W)) mIf12 ();

  fft_magni_peak #(.IN_W(IN_W), .ADDR_W(ADDR_W), .MAG_W(MAG_W), .MAG_SHIFT(0),
                   .FRAME_LEN(FLEN), .FCNT_W(FCNT_W)) dut (
    .sys_clk(clk), .sys_rst(rst), .s_axis_fft(sIf), .m_axis_fftmagni(mIf),
    .cfg_pk_lo(cfgLo), .cfg_pk_hi(cfgHi),
    .peak_valid(peakValid), .peak_mag(peakMag), .peak_addr(peakAddr),
    .peak_none(peakNone), .frame_cnt(frameCnt),
    .event_tlast_missing(evMissing), .event_tlast_unexpected(evUnexp)
  );

  fft_magni_peak #(.IN_W(IN_W), .ADDR_W(ADDR_W), .MAG_W(12), .MAG_SHIFT(0),
                   .FRAME_LEN(FLEN), .FCNT_W(FCNT_W)) dut12 (
    .sys_clk(clk), .sys_rst(rst), .s_axis_fft(sIf), .m_axis_fftmagni(mIf12),
    .cfg_pk_lo(cfgLo), .cfg_pk_hi(cfgHi),
    .peak_valid(p12Valid), .peak_mag(p12Mag), .peak_addr(p12Addr),
    .peak_none(p12None), .frame_cnt(f12Cnt),
    .event_tlast_missing(ev12Missing), .event_tlast_unexpected(ev12Unexp)
  );

  function automatic int sat(input int v, input int maxV);
    return (v > maxV) ? maxV : v;
  endfunction

  function automatic int refMag(input int re, input int im);
    int a, b, mx, mn;
    a = (re < 0) ? -re : re;
    b = (im < 0) ? -im : im;
    mx = (a > b) ? a : b;
    mn = (a > b) ? b : a;
    return mx + mn / 4 + mn / 8;
  endfunction

  function automatic int rnd16();
    logic signed [15:0] v;
    v = 16'($urandom);
    return int'(v);
  endfunction

  // First in-window bin wins ties; no in-window bin reports magnitude 0 at the low bound.
  function automatic void findPeak(input int mags[$], input int addrs[$], input int lo,
                                   input int hi, output int pm, output int pa, output bit none);
    none = 1'b1;
    pm = 0;
    pa = lo;
    foreach (mags[i]) begin
      if (addrs[i] >= lo && addrs[i] <= hi && (none || mags[i] > pm)) begin
        pm = mags[i];
        pa = addrs[i];
        none = 1'b0;
      end
    end
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (pend) begin
      checkOutput("peak_valid", peakValid, 1);
      checkOutput("peak_mag", peakMag, pendPeak.pkMag);
      checkOutput("peak_addr", peakAddr, pendPeak.pkAddr);
      checkOutput("peak_none", peakNone, pendPeak.pkNone);
      checkOutput("frame_cnt", frameCnt, pendPeak.fcnt);
      checkOutput("peak_valid12", p12Valid, 1);
      checkOutput("peak_mag12", p12Mag, pendPeak.pkMag12);
      checkOutput("peak_addr12", p12Addr, pendPeak.pkAddr12);
      checkOutput("peak_none12", p12None, pendPeak.pkNone);
      checkOutput("frame_cnt12", f12Cnt, pendPeak.fcnt);
    end else begin
      checkOutput("peak_valid_idle", peakValid, 0);
      checkOutput("peak_valid12_idle", p12Valid, 0);
    end
    pend = 1'b0;
    if (expQ.size() == 3) begin
      e = expQ.pop_front();
      checkOutput("m_valid", mIf.valid, e.vld);
      checkOutput("m_valid12", mIf12.valid, e.vld);
      checkOutput("ev_unexpected", evUnexp, e.evU);
      checkOutput("ev_missing", evMissing, e.evM);
      checkOutput("ev_unexpected12", ev12Unexp, e.evU);
      checkOutput("ev_missing12", ev12Missing, e.evM);
      if (e.vld) begin
        checkOutput("m_data", mIf.data, e.mag);
        checkOutput("m_addr", mIf.addr, e.addr);
        checkOutput("m_last", mIf.last, e.last);
        checkOutput("m_data12", mIf12.data, e.mag12);
        checkOutput("m_addr12", mIf12.addr, e.addr);
        checkOutput("m_last12", mIf12.last, e.last);
      end
      if (e.close) begin
        pend = 1'b1;
        pendPeak = e;
      end
    end
  endtask

  task automatic applyStimulus(input int re, input int im, input int addr, input bit last);
    exp_t e;
    int m, pm, pa, pm12, pa12;
    bit none;
    sIf.valid = 1'b1;
    sIf.data  = {16'(im), 16'(re)};
    sIf.addr  = 16'(addr);
    sIf.last  = last;
    if (idx == 0) begin
      latLo = int'(cfgLo);
      latHi = int'(cfgHi);
      fMag.delete();
      fMag12.delete();
      fAddr.delete();
    end
    e = '{default: 0};
    m = refMag(re, im);
    e.vld   = 1'b1;
    e.mag   = sat(m, 65535);
    e.mag12 = sat(m, 4095);
    e.addr  = addr;
    e.evU   = last && (idx != FLEN - 1);
    e.evM   = !last && (idx == FLEN - 1);
    e.last  = last || (idx == FLEN - 1);
    e.close = e.last;
    fMag.push_back(e.mag);
    fMag12.push_back(e.mag12);
    fAddr.push_back(addr);
    if (e.close) begin
      findPeak(fMag, fAddr, latLo, latHi, pm, pa, none);
      findPeak(fMag12, fAddr, latLo, latHi, pm12, pa12, none);
      e.pkMag = pm;
      e.pkAddr = pa;
      e.pkMag12 = pm12;
      e.pkAddr12 = pa12;
      e.pkNone = none;
      frameCount = (frameCount + 1) % 256;
      e.fcnt = frameCount;
      idx = 0;
    end else begin
      idx++;
    end
    expQ.push_back(e);
    tick();
  endtask

  task automatic applyIdle();
    exp_t e;
    sIf.valid = 1'b0;
    sIf.data  = '0;
    sIf.addr  = '0;
    sIf.last  = 1'b0;
    e = '{default: 0};
    expQ.push_back(e);
    tick();
  endtask

  // One reset cycle; everything visible must read zero right after it.
  task automatic doReset();
    rst = 1'b1;
    sIf.valid = 1'b0;
    sIf.data  = '0;
    sIf.addr  = '0;
    sIf.last  = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rst_m_valid", mIf.valid, 0);
    checkOutput("rst_m_data", mIf.data, 0);
    checkOutput("rst_m_addr", mIf.addr, 0);
    checkOutput("rst_m_last", mIf.last, 0);
    checkOutput("rst_peak_valid", peakValid, 0);
    checkOutput("rst_peak_mag", peakMag, 0);
    checkOutput("rst_peak_addr", peakAddr, 0);
    checkOutput("rst_peak_none", peakNone, 0);
    checkOutput("rst_frame_cnt", frameCnt, 0);
    checkOutput("rst_ev_missing", evMissing, 0);
    checkOutput("rst_ev_unexpected", evUnexp, 0);
    checkOutput("rst_m_valid12", mIf12.valid, 0);
    checkOutput("rst_frame_cnt12", f12Cnt, 0);
    rst = 1'b0;
    expQ.delete();
    pend = 1'b0;
    idx = 0;
    frameCount = 0;
  endtask

  initial begin
    rst = 1'b1;
    cfgLo = '0;
    cfgHi = 16'hFFFF;
    doReset();
    repeat (2) applyIdle();

    applyStimulus(-800, 600, 5, 1'b1);
    repeat (5) applyIdle();
    applyStimulus(-32768, -32768, 0, 1'b1);
    repeat (5) applyIdle();

    cfgLo = 16'd2;
    cfgHi = 16'd6;
    for (int i = 0; i < 8; i++) applyStimulus(pkMags[i], 0, i, i == 7);
    repeat (4) applyIdle();
    cfgLo = 16'd9;
    cfgHi = 16'd12;
    for (int i = 0; i < 8; i++) applyStimulus(pkMags[i], 0, i, i == 7);
    repeat (4) applyIdle();

    cfgLo = 16'd0;
    cfgHi = 16'd7;
    for (int i = 0; i < 5; i++) applyStimulus(rnd16(), rnd16(), i, i == 4);
    repeat (4) applyIdle();
    for (int i = 0; i < 8; i++) applyStimulus(rnd16(), rnd16(), i, 1'b0);
    repeat (4) applyIdle();

    for (int f = 0; f < 10; f++) begin
      int len;
      bit dropLast;
      cfgLo = 16'($urandom_range(0, 9));
      cfgHi = 16'($urandom_range(0, 9));
      len = ($urandom_range(0, 2) == 0) ? int'($urandom_range(6, 7)) : FLEN;
      dropLast = (len == FLEN) && ($urandom_range(0, 1) == 1);
      for (int i = 0; i < len; i++) begin
        if (i == 5) begin
          cfgLo = 16'($urandom_range(0, 9));
          cfgHi = 16'($urandom_range(0, 9));
        end
        applyStimulus(rnd16(), rnd16(), i, (i == len - 1) && !dropLast);
      end
      repeat ($urandom_range(0, 2)) applyIdle();
    end
    repeat (4) applyIdle();

    doReset();
    cfgLo = 16'd0;
    cfgHi = 16'd7;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 8; i++) applyStimulus(rnd16(), rnd16(), i, i == 7);
    end
    for (int i = 0; i < 5; i++) applyStimulus(rnd16(), rnd16(), i, 1'b0);
    doReset();
    repeat (6) applyIdle();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule

// File: doc/fft_magni_peak.md
Name: fft_magni_peak

Overview:
- Parametrised successor to the FFT-magnitude stage; the magnitude datapath is self-contained RTL with no CORDIC IP.
- Accepts complex FFT bins carrying their bin address and frame-last flag, and outputs a per-bin magnitude estimate (alpha-max-plus-beta-min) over a fixed 3-cycle pipeline, with address and last flag aligned.
- Also searches each frame for its peak bin inside a runtime bin window and reports it once per frame.
- Flags framing errors (missing or early last).
- Sits between the FFT core output and the spectrum writer / UART framer.

Parameters:
- IN_W, 40, signed width of each real/imag component.
- ADDR_W, 16, bin address width.
- MAG_W, 16, output magnitude width.
- MAG_SHIFT, 24, right shift applied to the raw magnitude before saturation.
- FRAME_LEN, 16384, bins per frame.
- FCNT_W, 8, width of the frame counter.

Ports:
- sys_clk  in  1  single clock.
- sys_rst  in  1  synchronous reset, active high.
- s_axis_fft_data  in  2*IN_W  {imag, real}, two's complement.
- s_axis_fft_valid  in  1  bin valid; no backpressure, no tready.
- s_axis_fft_addr  in  ADDR_W  bin index.
- s_axis_fft_last  in  1  last bin of frame.
- cfg_pk_lo  in  ADDR_W  peak window low bound, inclusive.
- cfg_pk_hi  in  ADDR_W  peak window high bound, inclusive.
- m_axis_fftmagni_valid  out  1  magnitude valid.
- m_axis_fftmagni_data  out  MAG_W  magnitude.
- m_axis_fftmagni_addr  out  ADDR_W  aligned bin index.
- m_axis_fftmagni_last  out  1  aligned last (includes forced close).
- peak_valid  out  1  one-cycle pulse per closed frame.
- peak_mag  out  MAG_W  peak magnitude.
- peak_addr  out  ADDR_W  peak bin index.
- peak_none  out  1  no bin of the frame fell inside the window.
- frame_cnt  out  FCNT_W  closed-frame count.
- event_tlast_missing  out  1  pulse: FRAME_LEN bins received without last.
- event_tlast_unexpected  out  1  pulse: last received before FRAME_LEN bins.

Behaviour:
- Reset: one clock, synchronous, active high, as already decided.
  - While sys_rst=1 at a clock edge, all outputs, pipeline valids, counters and the peak tracker clear to 0, and the FSM goes to IDLE.
  - A partial frame in flight is discarded; no peak_valid is produced for it.
- Pipeline, always advancing, valid/addr/last carried alongside the data:
  - S1: register |re| and |im|, each IN_W bits unsigned; abs(-2^(IN_W-1)) = 2^(IN_W-1), exact.
  - S2: register mx = max(|re|,|im|) and mn = min(|re|,|im|).
  - S3: raw = mx + (mn>>2) + (mn>>3), IN_W+1 bits. out = raw>>MAG_SHIFT, saturated to 2^MAG_W-1.
  - Latency: input valid at cycle t gives m_axis_fftmagni_valid at t+3. Gaps in valid pass through unchanged.
- Framing, on the S3 output side, using an index counter idx (0..FRAME_LEN-1) of valid output bins:
  - close = valid and (last or idx==FRAME_LEN-1).
  - last and idx!=FRAME_LEN-1: event_tlast_unexpected pulses with that bin.
  - idx==FRAME_LEN-1 and !last: event_tlast_missing pulses, and m_axis_fftmagni_last is forced to 1.
  - idx resets to 0 after close.
- FSM:
  - IDLE: on a valid output bin, latch cfg_pk_lo/hi into internal bounds (held for the whole frame) and go to RUN. If that bin also closes the frame (FRAME_LEN=1 or early last), close at once and stay in IDLE.
  - RUN: track the peak over valid bins; on close go to IDLE.
- Peak tracking:
  - A bin is in-window if lo <= addr <= hi; lo>hi means an empty window.
  - Update on strict greater-than, so ties keep the earliest bin.
  - The closing bin is included in the comparison.
- Report, in the cycle after close:
  - peak_valid=1 for one cycle; peak_mag/peak_addr/peak_none are updated in the same cycle and held until the next report.
  - If no bin was in-window: peak_none=1, peak_mag=0, peak_addr=lo.
  - frame_cnt increments, wrapping at 2^FCNT_W.
- Back-to-back frames: the tracker clears on the close edge, so the next frame's first bin may arrive in the cycle after close (the report cycle) with no loss.
- Config changes during a frame do not affect that frame.

Test Plan:
- Single-bin path: IN_W=16, MAG_SHIFT=0, MAG_W=16. Bin re=-800, im=600, addr=5 at cycle t -> valid at t+3, data=1025, addr=5.
- Extremes: re=im=-32768 -> data=45056. Same input with MAG_W=12 -> 4095, saturated.
- Peak window: FRAME_LEN=8, window [2,6], magnitudes by addr 0..7 = 900,10,40,70,70,20,10,999, last on addr 7.
  - peak_valid pulses 1 cycle after the last output bin, with peak_mag=70, peak_addr=3 (tie keeps earliest), peak_none=0, frame_cnt=1.
  - Repeat with window [9,12] -> peak_none=1, peak_mag=0, peak_addr=9.
- Framing errors, FRAME_LEN=8:
  - Last on the 5th bin -> event_tlast_unexpected pulses with that output bin, peak reported over 5 bins.
  - No last for 8 bins -> event_tlast_missing pulses, m_axis_fftmagni_last=1 on the 8th bin.
- Back-to-back frames plus mid-frame reset:
  - Two 8-bin frames with no gap -> two peak_valid pulses 8 cycles apart, frame_cnt=2.
  - sys_rst asserted after bin 4 of a third frame -> all outputs 0 the next cycle, no peak_valid, frame_cnt=0.
